// File: rtl/bcd_run_ctrl.sv
// Run controller for a two-digit BCD counter (00-99): START/STOP/CLR command FSM,
// prescaled count tick, cascaded digit enables, wrap or one-shot stop at a BCD target.
module bcd_run_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLR,
  input  logic       MODE,
  input  logic [7:0] TARGET,
  output logic       EN_ONES,
  output logic       EN_TENS,
  output logic [7:0] DOUT,
  output logic       COUT,
  output logic       DONE,
  output logic       BUSY
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [3:0] NINE = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HOLD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0]    ones, tens, ones_n, tens_n;
  logic [3:0]    inc_ones, inc_tens;
  logic          cout_n, done_n, busy_n;
  logic          tick, wrap, target_hit;

  // A tick is suppressed by any STOP/CLR in the same cycle
  assign tick    = (state == RUN) && (pre == PRE_LAST) && !STOP && !CLR;
  assign EN_ONES = tick;
  assign EN_TENS = tick && (ones == NINE);
  assign DOUT    = {tens, ones};

  // Post-tick BCD value; digits never exceed 9, so a malformed TARGET cannot match
  always_comb begin
    inc_ones = ones + 4'd1;
    inc_tens = tens;
    wrap     = 1'b0;
    if (ones == NINE) begin
      inc_ones = 4'd0;
      if (tens == NINE) begin
        inc_tens = 4'd0;
        wrap     = 1'b1;
      end else begin
        inc_tens = tens + 4'd1;
      end
    end
    target_hit = ({inc_tens, inc_ones} == TARGET);
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    pre_n   = pre;
    ones_n  = ones;
    tens_n  = tens;
    cout_n  = 1'b0;
    done_n  = 1'b0;
    if (CLR) begin
      state_n = IDLE;
      pre_n   = '0;
      ones_n  = 4'd0;
      tens_n  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state_n = RUN;
            pre_n   = '0;
          end
        end
        RUN: begin
          if (STOP) begin
            state_n = PAUSE;
          end else if (tick) begin
            pre_n  = '0;
            ones_n = inc_ones;
            tens_n = inc_tens;
            cout_n = wrap;
            if (MODE && target_hit) begin
              done_n  = 1'b1;
              state_n = HOLD;
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        PAUSE: begin
          if (START) state_n = RUN;
        end
        HOLD: begin
          if (START) begin
            state_n = RUN;
            pre_n   = '0;
            ones_n  = 4'd0;
            tens_n  = 4'd0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n == RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pre   <= '0;
      ones  <= 4'd0;
      tens  <= 4'd0;
      COUT  <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      ones  <= ones_n;
      tens  <= tens_n;
      COUT  <= cout_n;
      DONE  <= done_n;
      BUSY  <= busy_n;
    end
  end

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Self-checking bench for bcd_run_ctrl: directed scenarios with literal expectations
// plus randomized commands checked every cycle against an integer-count model.
module tb_bcd_run_ctrl;

  localparam int DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_HOLD = 3;

  logic       CLK = 1'b0;
  logic       RST, START, STOP, CLR, MODE;
  logic [7:0] TARGET;
  logic       EN_ONES, EN_TENS, COUT, DONE, BUSY;
  logic [7:0] DOUT;

  int total = 0;
  int bad = 0;

  // Model: count held as a plain integer 0..99, tick phase as an integer
  int m_st = S_IDLE;
  int m_cnt = 0;
  int m_pre = 0;
  bit m_cout = 1'b0;
  bit m_done = 1'b0;

  bcd_run_ctrl #(.DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .CLR(CLR), .MODE(MODE),
    .TARGET(TARGET), .EN_ONES(EN_ONES), .EN_TENS(EN_TENS), .DOUT(DOUT),
    .COUT(COUT), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int target_val(input logic [7:0] t);
    if (t[7:4] > 4'd9 || t[3:0] > 4'd9) return -1;
    return int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_st = S_IDLE; m_cnt = 0; m_pre = 0; m_cout = 0; m_done = 0;
    end else begin
      m_cout = 0;
      m_done = 0;
      if (CLR) begin
        m_st = S_IDLE; m_cnt = 0; m_pre = 0;
      end else if (m_st == S_IDLE) begin
        if (START) begin m_st = S_RUN; m_pre = 0; end
      end else if (m_st == S_PAUSE) begin
        if (START) m_st = S_RUN;
      end else if (m_st == S_HOLD) begin
        if (START) begin m_st = S_RUN; m_cnt = 0; m_pre = 0; end
      end else begin
        if (STOP) m_st = S_PAUSE;
        else if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_cnt = (m_cnt + 1) % 100;
          m_cout = (m_cnt == 0);
          if (MODE && target_val(TARGET) == m_cnt) begin
            m_done = 1; m_st = S_HOLD;
          end
        end else m_pre++;
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge CLK) begin
    logic exp_en;
    exp_en = !RST && m_st == S_RUN && m_pre == DIV - 1 && !STOP && !CLR;
    check("dout", DOUT, bcd(m_cnt));
    check("busy", 8'(BUSY), 8'(m_st == S_RUN));
    check("cout", 8'(COUT), 8'(m_cout));
    check("done", 8'(DONE), 8'(m_done));
    check("en_ones", 8'(EN_ONES), 8'(exp_en));
    check("en_tens", 8'(EN_TENS), 8'(exp_en && (m_cnt % 10 == 9)));
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    START = s; STOP = p; CLR = c;
    step(1);
    START = 0; STOP = 0; CLR = 0;
  endtask

  task automatic wait_dout(input logic [7:0] v, input int budget);
    int n = 0;
    while (DOUT !== v && n < budget) begin step(1); n++; end
    check("wait_dout", 8'(DOUT === v), 8'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin step(1); n++; end
    check("wait_done", 8'(DONE === 1'b1), 8'd1);
  endtask

  initial begin
    int dn, cn, n, r;
    START = 0; STOP = 0; CLR = 0; MODE = 0; TARGET = 8'h00; RST = 0;
    #1 RST = 1;
    step(2);
    check("rst_dout", DOUT, 8'h00);
    check("rst_busy", 8'(BUSY), 8'd0);
    check("rst_en", 8'({EN_ONES, EN_TENS, COUT, DONE}), 8'd0);
    RST = 0;
    step(1);

    // Basic count, DIV = 4
    pulse(1, 0, 0);
    check("t1_busy", 8'(BUSY), 8'd1);
    step(3);
    check("t1_en_before", 8'(EN_ONES), 8'd1);
    check("t1_dout_before", DOUT, 8'h00);
    step(1);
    check("t1_dout1", DOUT, 8'h01);
    check("t1_en_after", 8'(EN_ONES), 8'd0);
    step(4);
    check("t1_dout2", DOUT, 8'h02);

    // Wrap 99 -> 00
    wait_dout(8'h99, 420);
    n = 0;
    while (EN_ONES !== 1'b1 && n < DIV) begin step(1); n++; end
    check("t2_en_tens", 8'(EN_TENS), 8'd1);
    step(1);
    check("t2_dout", DOUT, 8'h00);
    check("t2_cout", 8'(COUT), 8'd1);
    step(1);
    check("t2_cout_gone", 8'(COUT), 8'd0);

    // One-shot to 23, hold, restart
    MODE = 1; TARGET = 8'h23;
    wait_done(150);
    check("t3_dout", DOUT, 8'h23);
    check("t3_busy", 8'(BUSY), 8'd0);
    step(50);
    check("t3_hold", DOUT, 8'h23);
    check("t3_done_gone", 8'(DONE), 8'd0);
    pulse(1, 0, 0);
    step(4);
    check("t3_restart", DOUT, 8'h01);
    TARGET = 8'h3A;
    dn = 0; cn = 0;
    repeat (440) begin step(1); dn += int'(DONE); cn += int'(COUT); end
    check("t3_no_done", 8'(dn), 8'd0);
    check("t3_one_wrap", 8'(cn), 8'd1);

    // Pause / resume with kept phase
    MODE = 0;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    step(62);
    check("t4_at15", DOUT, 8'h15);
    pulse(0, 1, 0);
    check("t4_paused", 8'(BUSY), 8'd0);
    step(20);
    check("t4_hold15", DOUT, 8'h15);
    pulse(1, 0, 0);
    step(1);
    check("t4_tick_phase", 8'(EN_ONES), 8'd1);
    step(1);
    check("t4_dout16", DOUT, 8'h16);
    step(3);
    STOP = 1;
    #1 check("t4_stop_kills_en", 8'(EN_ONES), 8'd0);
    step(1);
    STOP = 0;
    check("t4_no_inc", DOUT, 8'h16);
    check("t4_busy0", 8'(BUSY), 8'd0);
    pulse(1, 0, 0);
    check("t4_resume_tick", 8'(EN_ONES), 8'd1);
    step(1);
    check("t4_dout17", DOUT, 8'h17);

    // CLR priority in RUN, PAUSE and HOLD
    pulse(1, 1, 1);
    check("t5_run_clr", DOUT, 8'h00);
    check("t5_run_busy", 8'(BUSY), 8'd0);
    pulse(1, 0, 0);
    step(9);
    pulse(0, 1, 0);
    check("t5_paused02", DOUT, 8'h02);
    pulse(0, 0, 1);
    check("t5_pause_clr", DOUT, 8'h00);
    check("t5_pause_busy", 8'(BUSY), 8'd0);
    pulse(1, 0, 0);
    step(4);
    check("t5_idle_start", DOUT, 8'h01);
    MODE = 1; TARGET = 8'h02;
    wait_done(20);
    check("t5_hold02", DOUT, 8'h02);
    pulse(0, 0, 1);
    check("t5_hold_clr", DOUT, 8'h00);
    check("t5_hold_busy", 8'(BUSY), 8'd0);
    MODE = 0;

    // Asynchronous reset mid-cycle
    pulse(1, 0, 0);
    wait_dout(8'h47, 300);
    #2 RST = 1;
    #1;
    check("t6_rst_dout", DOUT, 8'h00);
    check("t6_rst_flags", 8'({BUSY, COUT, DONE, EN_ONES, EN_TENS}), 8'd0);
    step(2);
    RST = 0;
    step(1);
    pulse(1, 0, 0);
    step(4);
    check("t6_restart", DOUT, 8'h01);

    // Randomized commands against the model
    pulse(0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      START = (r < 20);
      STOP = (r >= 20 && r < 26);
      CLR = (r == 199);
      if (r == 198) begin START = 1; STOP = 1; CLR = 1; end
      if ($urandom_range(0, 149) == 0) MODE = ~MODE;
      if ($urandom_range(0, 79) == 0) begin
        n = $urandom_range(0, 9);
        if (n == 0) TARGET = 8'hA5;
        else if (n == 1) TARGET = 8'h3A;
        else if (n == 2) TARGET = 8'h00;
        else TARGET = bcd($urandom_range(0, 40));
      end
      step(1);
    end
    START = 0; STOP = 0; CLR = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_run_ctrl.md
# bcd_run_ctrl

Run controller for the two-digit decimal (00–99) counting datapath. It accepts START/STOP/CLR commands and divides CLK down to a count tick with a prescaler. It generates the cascaded digit enables and the BCD count, and supports free-running wrap or one-shot stop at a programmable BCD target. It sits between the panel/command logic and the display and decoder stages that consume DOUT, COUT and DONE.

## Interface
Parameters:
- DIV, 4, prescaler ratio: one count tick every DIV CLK cycles; legal range DIV ≥ 1.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  run command, level sampled each edge.
- STOP  in  1  pause command.
- CLR  in  1  clear command.
- MODE  in  1  0 = wrap 99→00 forever; 1 = one-shot, stop at TARGET.
- TARGET  in  8  BCD stop value {tens[7:4], ones[3:0]}, sampled continuously.
- EN_ONES  out  1  combinational ones-digit enable, high in a tick cycle.
- EN_TENS  out  1  combinational tens-digit enable, EN_ONES & (ones == 9).
- DOUT  out  8  registered BCD count {tens, ones}.
- COUT  out  1  registered one-cycle pulse on the 99→00 wrap.
- DONE  out  1  registered one-cycle pulse when DOUT reaches TARGET in MODE=1.
- BUSY  out  1  high while the state is RUN.

## Operation
- States: IDLE, RUN, PAUSE, HOLD.
- Reset values: IDLE, DOUT = 00, prescaler = 0, COUT = DONE = BUSY = EN_ONES = EN_TENS = 0.
- Command priority is CLR > STOP > START.
- CLR in any state goes to IDLE, with DOUT = 00 and prescaler = 0.
- IDLE: START goes to RUN and clears the prescaler. STOP is ignored.
- RUN: STOP goes to PAUSE. START is ignored.
- PAUSE: START returns to RUN. DOUT and the prescaler are retained, so tick phase continues.
- HOLD: START goes to RUN, restarting from DOUT = 00 with prescaler = 0. STOP is ignored.
- Prescaler: counts 0..DIV-1 only in RUN, then wraps to 0. A tick is RUN & prescaler == DIV-1 & no STOP/CLR that cycle. With DIV = 1, every RUN cycle is a tick.
- On a tick:
  - ones ≠ 9: ones increments.
  - ones = 9: ones becomes 0 and tens increments.
  - DOUT = 99: DOUT becomes 00 and COUT pulses.
- Target match (MODE = 1): if the post-tick value equals TARGET, DONE pulses on the same edge, the state goes to HOLD and BUSY drops.
- A TARGET with either digit > 9 never matches.
- TARGET = 00 matches on the wrap; COUT and DONE then pulse together.
- Starting with DOUT already equal to TARGET does not produce DONE. Matching only happens on a tick.
- MODE changed mid-run takes effect at the next tick.
- DOUT digits are always ≤ 9.

## Timing
- Let START be sampled at edge 0 from IDLE/HOLD. BUSY is high after edge 0.
- EN_ONES is high during the cycle after edge DIV-1. DOUT increments at edge DIV.
- Ticks repeat every DIV cycles after that.
- STOP sampled at edge s: BUSY is low after edge s. If edge s coincided with a tick, no increment occurs.
- COUT and DONE rise on the same edge as the DOUT update they mark and last exactly one cycle.
- RST assertion forces reset values immediately, with no clock edge required. Release is synchronous to the next edge.

## Test plan
- DIV = 4, MODE = 0, START at edge 0: DOUT 00→01 at edge 4, 02 at edge 8. EN_ONES is one cycle wide before each update. BUSY = 1.
- Run through to DOUT = 99: EN_TENS and EN_ONES are both high in the tick cycle. The next edge gives DOUT = 00 and a one-cycle COUT, and counting continues.
- MODE = 1, TARGET = 0x23: DONE pulses once as DOUT becomes 23, then BUSY = 0 and DOUT holds 23 for 50 cycles. START then gives DOUT = 01 after 4 more cycles. With TARGET = 0x3A the count wraps past 99 and DONE never fires.
- STOP at DOUT = 15 with prescaler = 2, hold 20 cycles: DOUT stays 15. START resumes and DOUT = 16 after 2 cycles (phase kept). STOP coincident with a tick gives no increment.
- CLR, STOP and START asserted in the same RUN cycle: next state IDLE, DOUT = 00, BUSY = 0. CLR in PAUSE and in HOLD gives the same result.
- RST pulsed asynchronously mid-cycle during RUN at DOUT = 47: all outputs reach reset values before the next CLK edge. After release, a START restarts from 00.
